// File: rtl/ecore_gpio.sv
// Memory-mapped GPIO: output/direction/mask registers, synchronised pin inputs,
// rising-edge latches with write-1-to-clear, and a level interrupt.
module ecore_gpio #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned SYNC_DEPTH = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_sel,
    input  logic [3:0]        i_we,
    input  logic              i_re,
    input  logic [29:0]       i_addr,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata,
    output logic              o_rvalid,
    output logic              o_irq,
    inout  wire  [WIDTH-1:0]  io_gpio_bank
);

    localparam logic [2:0] ADDR_OUT  = 3'd0;
    localparam logic [2:0] ADDR_DIR  = 3'd1;
    localparam logic [2:0] ADDR_IN   = 3'd2;
    localparam logic [2:0] ADDR_EDGE = 3'd3;
    localparam logic [2:0] ADDR_MASK = 3'd4;
    localparam logic [2:0] ADDR_SET  = 3'd5;
    localparam logic [2:0] ADDR_CLR  = 3'd6;

    localparam int unsigned          WARM_W    = $clog2(SYNC_DEPTH + 2);
    localparam logic [WARM_W-1:0]    WARM_DONE = WARM_W'(SYNC_DEPTH + 1);

    logic [WIDTH-1:0]  out_q, dir_q, edge_q, mask_q, prev_q;
    logic [WIDTH-1:0]  sync_q [SYNC_DEPTH];
    logic [WARM_W-1:0] warm_cnt_q;

    logic [WIDTH-1:0]  in_c, out_d, dir_d, edge_d, mask_d, w1c, edge_new, be_w, wbits;
    logic [31:0]       be_mask, rdata_d;
    logic              wr_en, rd_en, warm_done;

    assign in_c      = sync_q[SYNC_DEPTH-1];
    assign warm_done = (warm_cnt_q == WARM_DONE);
    assign wr_en     = i_sel & (|i_we);
    assign rd_en     = i_sel & i_re;
    assign be_mask   = {{8{i_we[3]}}, {8{i_we[2]}}, {8{i_we[1]}}, {8{i_we[0]}}};
    assign be_w      = be_mask[WIDTH-1:0];
    assign wbits     = i_wdata[WIDTH-1:0] & be_w;

    // Bits above WIDTH and upper address bits are intentionally ignored.
    logic unused_ok;
    assign unused_ok = ^{i_addr[29:3], i_wdata, be_mask};

    // Pin drivers: output where DIR is set, released otherwise.
    for (genvar g = 0; g < WIDTH; g++) begin : g_pin
        assign io_gpio_bank[g] = dir_q[g] ? out_q[g] : 1'bz;
    end

    // Register next-state and read mux.
    always_comb begin
        out_d    = out_q;
        dir_d    = dir_q;
        mask_d   = mask_q;
        w1c      = '0;
        rdata_d  = '0;
        edge_new = warm_done ? (in_c & ~prev_q) : '0;
        if (wr_en) begin
            case (i_addr[2:0])
                ADDR_OUT:  out_d  = (out_q & ~be_w) | wbits;
                ADDR_DIR:  dir_d  = (dir_q & ~be_w) | wbits;
                ADDR_EDGE: w1c    = wbits;
                ADDR_MASK: mask_d = (mask_q & ~be_w) | wbits;
                ADDR_SET:  out_d  = out_q | wbits;
                ADDR_CLR:  out_d  = out_q & ~wbits;
                default:   ;
            endcase
        end
        // A new edge overrides a clear of the same bit.
        edge_d = (edge_q & ~w1c) | edge_new;
        case (i_addr[2:0])
            ADDR_OUT:  rdata_d = 32'(out_q);
            ADDR_DIR:  rdata_d = 32'(dir_q);
            ADDR_IN:   rdata_d = 32'(in_c);
            ADDR_EDGE: rdata_d = 32'(edge_q);
            ADDR_MASK: rdata_d = 32'(mask_q);
            default:   rdata_d = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            out_q      <= '0;
            dir_q      <= '0;
            edge_q     <= '0;
            mask_q     <= '0;
            prev_q     <= '0;
            warm_cnt_q <= '0;
            o_rdata    <= '0;
            o_rvalid   <= 1'b0;
            o_irq      <= 1'b0;
            for (int i = 0; i < SYNC_DEPTH; i++) sync_q[i] <= '0;
        end else begin
            out_q    <= out_d;
            dir_q    <= dir_d;
            edge_q   <= edge_d;
            mask_q   <= mask_d;
            prev_q   <= in_c;
            o_irq    <= |(edge_d & mask_d);
            o_rvalid <= rd_en;
            if (rd_en) o_rdata <= rdata_d;
            if (!warm_done) warm_cnt_q <= warm_cnt_q + WARM_W'(1);
            sync_q[0] <= io_gpio_bank;
            for (int i = 1; i < SYNC_DEPTH; i++) sync_q[i] <= sync_q[i-1];
        end
    end

endmodule

// File: tb/tb_ecore_gpio.sv
// Directed self-checking bench for ecore_gpio: registers, pins, edges, irq, warm-up.
module tb_ecore_gpio;

    localparam logic [2:0] A_OUT  = 3'd0;
    localparam logic [2:0] A_DIR  = 3'd1;
    localparam logic [2:0] A_IN   = 3'd2;
    localparam logic [2:0] A_EDGE = 3'd3;
    localparam logic [2:0] A_MASK = 3'd4;
    localparam logic [2:0] A_SET  = 3'd5;
    localparam logic [2:0] A_CLR  = 3'd6;
    localparam logic [2:0] A_RSV  = 3'd7;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic [3:0]  we;
    logic        re;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;
    logic        irq;
    wire  [31:0] gpio;
    logic [31:0] tb_oe;
    logic [31:0] tb_drv;

    int errors = 0;
    int checks = 0;

    logic [31:0] rd;
    logic        rv;

    for (genvar g = 0; g < 32; g++) begin : g_drv
        assign gpio[g] = tb_oe[g] ? tb_drv[g] : 1'bz;
    end

    ecore_gpio #(.WIDTH(32), .SYNC_DEPTH(2)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_sel        (sel),
        .i_we         (we),
        .i_re         (re),
        .i_addr       (addr),
        .i_wdata      (wdata),
        .o_rdata      (rdata),
        .o_rvalid     (rvalid),
        .o_irq        (irq),
        .io_gpio_bank (gpio)
    );

    always #5 clk = ~clk;

    task automatic do_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        sel = 1'b1; we = be; re = 1'b0; addr = 30'(a); wdata = d;
        @(posedge clk); #1;
        sel = 1'b0; we = 4'b0;
    endtask

    task automatic do_read(input logic [2:0] a, output logic [31:0] d, output logic v);
        @(negedge clk);
        sel = 1'b1; re = 1'b1; we = 4'b0; addr = 30'(a);
        @(posedge clk); #1;
        d = rdata; v = rvalid;
        sel = 1'b0; re = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want %h", rdata, 32'h0); end
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b want 0", rvalid); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
        @(negedge clk); rst = 1'b0;
        do_read(A_DIR, rd, rv);
        checks++; if (rv !== 1'b1) begin errors++; $display("FAIL reset_read_valid: got %b want 1", rv); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_read_dir: got %h want %h", rd, 32'h0); end
        @(posedge clk); #1;
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL rvalid_pulse: got %b want 0", rvalid); end
        // reset in the same cycle as a read drops the pulse
        @(negedge clk);
        sel = 1'b1; re = 1'b1; addr = 30'(A_DIR); rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_mid_read: got %b want 0", rvalid); end
        sel = 1'b0; re = 1'b0;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_output;
        do_write(A_DIR, 32'h0000_00FF, 4'hF);
        do_read(A_DIR, rd, rv);
        checks++; if (rd !== 32'h0000_00FF) begin errors++; $display("FAIL dir_readback: got %h want %h", rd, 32'h0000_00FF); end
        tb_oe = 32'hFFFF_FF00;
        do_write(A_OUT, 32'h0000_00A5, 4'hF);
        checks++; if (gpio[7:0] !== 8'hA5) begin errors++; $display("FAIL pins_out: got %h want %h", gpio[7:0], 8'hA5); end
        do_write(A_SET, 32'h0000_0002, 4'hF);
        do_read(A_OUT, rd, rv);
        checks++; if (rd !== 32'h0000_00A7) begin errors++; $display("FAIL out_set: got %h want %h", rd, 32'h0000_00A7); end
        checks++; if (gpio[7:0] !== 8'hA7) begin errors++; $display("FAIL pins_set: got %h want %h", gpio[7:0], 8'hA7); end
        do_write(A_CLR, 32'h0000_0080, 4'hF);
        do_read(A_OUT, rd, rv);
        checks++; if (rd !== 32'h0000_0027) begin errors++; $display("FAIL out_clr: got %h want %h", rd, 32'h0000_0027); end
        checks++; if (gpio[7:0] !== 8'h27) begin errors++; $display("FAIL pins_clr: got %h want %h", gpio[7:0], 8'h27); end
        @(posedge clk); #1;
        checks++; if (rdata !== 32'h0000_0027 || rvalid !== 1'b0) begin
            errors++; $display("FAIL rdata_hold: got %h/%b want %h/0", rdata, rvalid, 32'h0000_0027); end
        do_read(A_SET, rd, rv);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL set_reads_zero: got %h want %h", rd, 32'h0); end
        do_write(A_CLR, 32'h0000_00FF, 4'hF);
        tb_oe = 32'hFFFF_FFFF;
        do_write(A_DIR, 32'h0, 4'hF);
    endtask

    task automatic test_byte_enables;
        do_write(A_OUT, 32'h1122_3344, 4'b0100);
        do_read(A_OUT, rd, rv);
        checks++; if (rd !== 32'h0022_0000) begin errors++; $display("FAIL byte_enable: got %h want %h", rd, 32'h0022_0000); end
        // read and write of OUT in the same cycle returns the old value
        @(negedge clk);
        sel = 1'b1; re = 1'b1; we = 4'hF; addr = 30'(A_OUT); wdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        sel = 1'b0; re = 1'b0; we = 4'h0;
        checks++; if (rdata !== 32'h0022_0000) begin errors++; $display("FAIL read_during_write: got %h want %h", rdata, 32'h0022_0000); end
        do_read(A_OUT, rd, rv);
        checks++; if (rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL write_after_rdw: got %h want %h", rd, 32'hFFFF_FFFF); end
        do_write(A_RSV, 32'hDEAD_BEEF, 4'hF);
        do_read(A_RSV, rd, rv);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reserved_reads_zero: got %h want %h", rd, 32'h0); end
        do_write(A_OUT, 32'h0, 4'hF);
    endtask

    task automatic test_edge_irq;
        repeat (4) @(posedge clk);
        do_write(A_EDGE, 32'hFFFF_FFFF, 4'hF);
        do_read(A_EDGE, rd, rv);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL edge_cleared: got %h want %h", rd, 32'h0); end
        @(negedge clk); tb_drv[3] = 1'b1;
        @(posedge clk); @(posedge clk);
        do_read(A_IN, rd, rv);
        checks++; if (rd !== 32'h0000_0008) begin errors++; $display("FAIL in_sync: got %h want %h", rd, 32'h0000_0008); end
        do_read(A_EDGE, rd, rv);
        checks++; if (rd !== 32'h0000_0008) begin errors++; $display("FAIL edge_latched: got %h want %h", rd, 32'h0000_0008); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_unmasked: got %b want 0", irq); end
        do_write(A_MASK, 32'h0000_0008, 4'hF);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_rise: got %b want 1", irq); end
        do_write(A_EDGE, 32'h0000_0008, 4'hF);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_fall: got %b want 0", irq); end
        do_read(A_EDGE, rd, rv);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL edge_w1c: got %h want %h", rd, 32'h0); end
    endtask

    task automatic test_collision;
        @(negedge clk); tb_drv[5] = 1'b1;
        @(posedge clk); @(posedge clk);
        do_write(A_EDGE, 32'h0000_0020, 4'hF);
        do_read(A_EDGE, rd, rv);
        checks++; if (rd !== 32'h0000_0020) begin errors++; $display("FAIL collision_set_wins: got %h want %h", rd, 32'h0000_0020); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL collision_irq_masked: got %b want 0", irq); end
        do_write(A_MASK, 32'h0000_0020, 4'hF);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL collision_irq: got %b want 1", irq); end
        do_write(A_EDGE, 32'h0000_0020, 4'hF);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL collision_irq_clear: got %b want 0", irq); end
    endtask

    task automatic test_warmup;
        @(negedge clk);
        rst = 1'b1; tb_drv[0] = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        repeat (10) @(posedge clk);
        do_read(A_EDGE, rd, rv);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL warmup_no_edge: got %h want %h", rd, 32'h0); end
        do_read(A_IN, rd, rv);
        checks++; if (rd !== 32'h0000_0029) begin errors++; $display("FAIL warmup_in: got %h want %h", rd, 32'h0000_0029); end
        @(negedge clk); tb_drv[2] = 1'b1;
        repeat (3) @(posedge clk);
        do_read(A_EDGE, rd, rv);
        checks++; if (rd !== 32'h0000_0004) begin errors++; $display("FAIL post_warmup_edge: got %h want %h", rd, 32'h0000_0004); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL post_warmup_irq: got %b want 0", irq); end
    endtask

    initial begin
        rst = 1'b1; sel = 1'b0; we = 4'h0; re = 1'b0; addr = '0; wdata = '0;
        tb_oe = 32'hFFFF_FFFF; tb_drv = 32'h0;
        test_reset();
        test_output();
        test_byte_enables();
        test_edge_irq();
        test_collision();
        test_warmup();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
